// File: rtl/riscv_uop_pkg.sv
// riscv_uop_pkg: shared issue-stage types and defaults
package riscv_uop_pkg;
    localparam int SB_MAX_LOADS = 4;
    typedef enum logic [1:0] {SB_RUN, SB_DRAIN, SB_DONE} sb_state_e;
endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: load-use and WAW hazard tracking for in-flight loads,
// LSU occupancy limit and fence drain sequencing.
module issue_scoreboard
    import riscv_uop_pkg::*;
#(
    parameter int MAX_LOADS = SB_MAX_LOADS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_cand_valid,
    input  logic [4:0]                     i_cand_rs1,
    input  logic [4:0]                     i_cand_rs2,
    input  logic [4:0]                     i_cand_rd,
    input  logic                           i_cand_uses_rs1,
    input  logic                           i_cand_uses_rs2,
    input  logic                           i_cand_writes_rd,
    input  logic                           i_cand_is_load,
    input  logic                           i_issue_fire,
    input  logic                           i_flush,
    input  logic                           i_drain_req,
    input  logic                           i_lsu_wb_valid,
    input  logic [4:0]                     i_lsu_wb_rd,
    output logic                           o_hazard_stall,
    output logic [31:0]                    o_pending,
    output logic [$clog2(MAX_LOADS+1)-1:0] o_outstanding,
    output logic                           o_drain_done,
    output logic                           o_err_spurious
);
    localparam int CW = $clog2(MAX_LOADS + 1);
    sb_state_e state, state_nxt;
    logic raw, waw, full, fire, dec, spurious;
    logic [CW-1:0] cnt_nxt;
    logic [31:0] set_vec, clr_vec;
    // A register whose load data returns this cycle is forwarded by the LSU, so it is not a hazard
    always_comb begin
        raw = (i_cand_uses_rs1 && i_cand_rs1 != 5'd0 && o_pending[i_cand_rs1] &&
               !(i_lsu_wb_valid && i_lsu_wb_rd == i_cand_rs1)) ||
              (i_cand_uses_rs2 && i_cand_rs2 != 5'd0 && o_pending[i_cand_rs2] &&
               !(i_lsu_wb_valid && i_lsu_wb_rd == i_cand_rs2));
        waw = i_cand_writes_rd && i_cand_rd != 5'd0 && o_pending[i_cand_rd] &&
              !(i_lsu_wb_valid && i_lsu_wb_rd == i_cand_rd);
        full = i_cand_is_load && o_outstanding == CW'(MAX_LOADS) && !i_lsu_wb_valid;
        o_hazard_stall = i_cand_valid && !i_flush && (raw || waw || full || state != SB_RUN);
        fire = i_issue_fire && !o_hazard_stall && !i_flush && i_cand_is_load;
        dec = i_lsu_wb_valid && o_outstanding != '0;
        spurious = i_lsu_wb_valid &&
                   (o_outstanding == '0 || (i_lsu_wb_rd != 5'd0 && !o_pending[i_lsu_wb_rd]));
        cnt_nxt = o_outstanding + CW'(fire) - CW'(dec);
        set_vec = (fire && i_cand_writes_rd) ? 32'd1 << i_cand_rd : 32'd0;
        clr_vec = i_lsu_wb_valid ? 32'd1 << i_lsu_wb_rd : 32'd0;
        state_nxt = state == SB_RUN   ? (i_drain_req ? SB_DRAIN : SB_RUN) :
                    state == SB_DRAIN ? (cnt_nxt == '0 ? SB_DONE : SB_DRAIN) : SB_RUN;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= SB_RUN;
            o_pending      <= '0;
            o_outstanding  <= '0;
            o_drain_done   <= 1'b0;
            o_err_spurious <= 1'b0;
        end else begin
            state          <= state_nxt;
            o_pending      <= ((o_pending & ~clr_vec) | set_vec) & ~32'd1;
            o_outstanding  <= cnt_nxt;
            o_drain_done   <= state_nxt == SB_DONE;
            o_err_spurious <= o_err_spurious | spurious;
        end
    end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed scenarios plus randomized traffic checked
// against a behavioural scoreboard model.
module tb_issue_scoreboard;
    localparam int MAXL = 4;
    logic clk = 0, rst_n = 0;
    logic cand_valid, uses1, uses2, writes, is_load, fire, flush, drain, wbv;
    logic [4:0] rs1, rs2, rd, wbrd;
    logic stall, done, err;
    logic [31:0] pend;
    logic [2:0] outst;
    int checks = 0, errors = 0;
    bit [31:0] m_pend;
    int m_cnt, m_mode;
    bit m_err, last_stall;
    logic [4:0] q[$];

    issue_scoreboard #(.MAX_LOADS(MAXL)) dut (
        .clk(clk), .rst_n(rst_n), .i_cand_valid(cand_valid), .i_cand_rs1(rs1),
        .i_cand_rs2(rs2), .i_cand_rd(rd), .i_cand_uses_rs1(uses1), .i_cand_uses_rs2(uses2),
        .i_cand_writes_rd(writes), .i_cand_is_load(is_load), .i_issue_fire(fire),
        .i_flush(flush), .i_drain_req(drain), .i_lsu_wb_valid(wbv), .i_lsu_wb_rd(wbrd),
        .o_hazard_stall(stall), .o_pending(pend), .o_outstanding(outst),
        .o_drain_done(done), .o_err_spurious(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_stall();
        bit hz;
        hz = (uses1 && rs1 != 0 && m_pend[rs1] && !(wbv && wbrd == rs1)) ||
             (uses2 && rs2 != 0 && m_pend[rs2] && !(wbv && wbrd == rs2)) ||
             (writes && rd != 0 && m_pend[rd] && !(wbv && wbrd == rd)) ||
             (is_load && m_cnt == MAXL && !wbv) || m_mode != 0;
        return cand_valid && !flush && hz;
    endfunction

    task automatic idle();
        {cand_valid, uses1, uses2, writes, is_load, fire, flush, drain, wbv} = '0;
        {rs1, rs2, rd, wbrd} = '0;
    endtask

    task automatic cand(input bit ld, input logic [4:0] d, input logic [4:0] s1, input bit f);
        cand_valid = 1; is_load = ld; rd = d; writes = 1; rs1 = s1; uses1 = s1 != 0;
        rs2 = 0; uses2 = 0; fire = f;
    endtask

    task automatic cyc(input string tag);
        bit st, fok;
        int nc;
        #1;
        st = m_stall();
        last_stall = stall;
        chk({tag, "_stall"}, {31'd0, stall}, {31'd0, st});
        fok = fire && !st && !flush && is_load;
        nc = m_cnt + int'(fok) - ((wbv && m_cnt > 0) ? 1 : 0);
        if (wbv && (m_cnt == 0 || (wbrd != 0 && !m_pend[wbrd]))) m_err = 1;
        if (wbv && wbrd != 0) m_pend[wbrd] = 0;
        if (fok && writes && rd != 0) m_pend[rd] = 1;
        if (fok) q.push_back((writes && rd != 0) ? rd : 5'd0);
        m_mode = m_mode == 0 ? (drain ? 1 : 0) : m_mode == 1 ? (nc == 0 ? 2 : 1) : 0;
        m_cnt = nc;
        @(posedge clk);
        #1;
        chk({tag, "_pend"}, pend, m_pend);
        chk({tag, "_cnt"}, {29'd0, outst}, m_cnt);
        chk({tag, "_done"}, {31'd0, done}, {31'd0, m_mode == 2});
        chk({tag, "_err"}, {31'd0, err}, {31'd0, m_err});
    endtask

    task automatic do_reset(input string tag);
        rst_n = 0;
        #1;
        chk({tag, "_rst_pend"}, pend, 0);
        chk({tag, "_rst_cnt"}, {29'd0, outst}, 0);
        chk({tag, "_rst_flags"}, {30'd0, done, err}, 0);
        m_pend = 0; m_cnt = 0; m_mode = 0; m_err = 0;
        q.delete();
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        idle();
        do_reset("init");
        // load-use on x5, bypassed in the writeback cycle
        cand(1, 5, 0, 1); cyc("ld5");
        idle(); cand(0, 6, 5, 0); cyc("raw1"); chk("raw1_lit", last_stall, 1);
        cyc("raw2"); chk("raw2_lit", last_stall, 1);
        fire = 1; wbv = 1; wbrd = 5; cyc("bypass"); chk("bypass_lit", last_stall, 0);
        chk("bypass_cnt", outst, 0);
        void'(q.pop_front());
        // LSU full
        for (int i = 1; i <= 4; i++) begin idle(); cand(1, 5'(i), 0, 1); cyc("fill"); end
        idle(); cand(1, 8, 0, 1); cyc("full"); chk("full_lit", last_stall, 1); chk("full_cnt", outst, 4);
        wbv = 1; wbrd = 1; cyc("full_wb"); chk("full_wb_lit", last_stall, 0);
        chk("full_wb_cnt", outst, 4); chk("full_wb_pend", pend, 32'h0000_011c);
        q.delete();
        foreach (q[i]) ;
        for (int i = 2; i <= 4; i++) begin idle(); wbv = 1; wbrd = 5'(i); cyc("drainq"); end
        idle(); wbv = 1; wbrd = 8; cyc("drainq8");
        // load to x0
        idle(); cand(1, 0, 0, 1); cyc("ld0"); chk("ld0_pend", pend, 0); chk("ld0_cnt", outst, 1);
        idle(); cand(0, 4, 0, 0); rs1 = 0; uses1 = 1; cyc("add_x0"); chk("add_x0_lit", last_stall, 0);
        idle(); wbv = 1; wbrd = 0; cyc("wb0"); chk("wb0_err", err, 0);
        // flush suppresses a new load but keeps x3 tracked
        idle(); cand(1, 3, 0, 1); cyc("ld3");
        idle(); cand(1, 9, 0, 1); flush = 1; cyc("flush");
        chk("flush_pend", pend, 32'h8); chk("flush_cnt", outst, 1);
        idle(); wbv = 1; wbrd = 3; cyc("wb3");
        // drain with two loads in flight
        idle(); cand(1, 10, 0, 1); cyc("ld10");
        idle(); cand(1, 11, 0, 1); cyc("ld11");
        idle(); cand_valid = 1; drain = 1; cyc("dreq");
        idle(); cand_valid = 1; cyc("dwait"); chk("dwait_lit", last_stall, 1);
        wbv = 1; wbrd = 10; cyc("dwb10"); chk("dwb10_done", done, 0);
        wbv = 1; wbrd = 11; cyc("dwb11"); chk("dwb11_done", done, 1);
        idle(); cand_valid = 1; cyc("ddone"); chk("ddone_lit", last_stall, 1); chk("ddone_done", done, 0);
        idle(); cand_valid = 1; cyc("drun"); chk("drun_lit", last_stall, 0);
        // spurious writeback is sticky until reset
        idle(); wbv = 1; wbrd = 7; cyc("spur"); chk("spur_err", err, 1); chk("spur_cnt", outst, 0);
        idle(); cyc("spur_hold"); chk("spur_hold_err", err, 1);
        do_reset("spur");
        // reset discards in-flight loads
        idle(); cand(1, 12, 0, 1); cyc("ld12");
        idle(); cand(1, 13, 0, 1); cyc("ld13");
        idle(); do_reset("mid");
        wbv = 1; wbrd = 12; cyc("post_rst_wb"); chk("post_rst_err", err, 1);
        idle(); do_reset("pre_rand");
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin idle(); do_reset("rand"); end
            idle();
            cand_valid = $urandom % 4 != 0;
            rs1 = 5'($urandom % 8); rs2 = 5'($urandom % 8); rd = 5'($urandom % 8);
            uses1 = 1'($urandom); uses2 = 1'($urandom); writes = $urandom % 4 != 0;
            is_load = 1'($urandom); fire = cand_valid && ($urandom % 4 != 0);
            flush = $urandom % 16 == 0; drain = $urandom % 25 == 0;
            if (q.size() > 0 && $urandom % 3 == 0) begin
                int k = int'($urandom % q.size());
                wbv = 1; wbrd = q[k]; q.delete(k);
            end else if ($urandom % 50 == 0) begin
                wbv = 1; wbrd = 5'($urandom % 32);
            end
            cyc("rand");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter MAX_LOADS, default 4, maximum loads in flight in LSU (2..15).
REQ-002 SHALL have ports: clk  in  1  clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: i_cand_valid  in  1  candidate uop held in issue register; i_cand_rs1, i_cand_rs2, i_cand_rd  in  5 each  register indices.
REQ-004 SHALL have ports: i_cand_uses_rs1, i_cand_uses_rs2, i_cand_writes_rd, i_cand_is_load  in  1 each  candidate attributes.
REQ-005 SHALL have ports: i_issue_fire  in  1  candidate dispatched this cycle; i_flush  in  1  pipeline flush; i_drain_req  in  1  fence/drain request, level.
REQ-006 SHALL have ports: i_lsu_wb_valid  in  1  load data returned; i_lsu_wb_rd  in  5  its destination.
REQ-007 SHALL have ports: o_hazard_stall  out  1; o_pending  out  32  per-register load-pending bits; o_outstanding  out  $clog2(MAX_LOADS+1)  loads in flight; o_drain_done  out  1  pulse; o_err_spurious  out  1  sticky error.

Function
REQ-008 SHALL set pending[rd] on the clock edge where i_issue_fire && i_cand_is_load && i_cand_writes_rd && rd!=0 && !i_flush.
REQ-009 SHALL clear pending[rd] on the edge where i_lsu_wb_valid, rd!=0; same-cycle set and clear of one rd SHALL leave the bit set.
REQ-010 SHALL keep pending[0] at 0 always.
REQ-011 SHALL increment o_outstanding on every fired load (including rd=0), decrement on every i_lsu_wb_valid; simultaneous inc/dec SHALL hold the value.
REQ-012 SHALL raise o_err_spurious, sticky until reset, on writeback with o_outstanding==0 or, for rd!=0, with pending[rd]==0; counter SHALL NOT underflow.
REQ-013 SHALL drive o_hazard_stall combinationally = i_cand_valid && !i_flush && (RAW || WAW || FULL || state!=RUN).
REQ-014 RAW SHALL be: (uses_rs1 && rs1!=0 && pending[rs1]) or same for rs2, excluding a register whose writeback arrives this cycle (i_lsu_wb_valid && i_lsu_wb_rd match), since LSU forwarding covers it.
REQ-015 WAW SHALL be: writes_rd && rd!=0 && pending[rd], with the same same-cycle writeback exclusion.
REQ-016 FULL SHALL be: i_cand_is_load && o_outstanding==MAX_LOADS && !i_lsu_wb_valid.
REQ-017 i_flush SHALL NOT clear pending bits or counter; in-flight loads are older than the flushing branch and complete normally.
REQ-018 SHALL implement FSM RUN, DRAIN, DONE: RUN->DRAIN when i_drain_req; DRAIN->DONE when o_outstanding==0 (next-state value); DONE->RUN unconditionally.
REQ-019 o_drain_done SHALL be 1 only in DONE (one-cycle pulse); i_drain_req held high re-enters DRAIN from RUN.
REQ-020 i_issue_fire while o_hazard_stall=1 SHALL be ignored (no set, no increment).

Reset
REQ-021 On rst_n low, asynchronously: o_pending=0, o_outstanding=0, state=RUN, o_drain_done=0, o_err_spurious=0.
REQ-022 Reset mid-drain or with loads in flight SHALL discard all tracking; writebacks arriving after reset release count as spurious.

Structure
REQ-023 FSM state enum sb_state_e and default SB_MAX_LOADS SHALL live in riscv_uop_pkg.
REQ-024 SHALL be a single flat module, no sub-modules; instantiated beside the issue stage, o_hazard_stall ORed into its stall.

Verification
REQ-025 Load x5 fires, next cycle candidate ADD uses rs1=x5 -> stall=1 until writeback rd=5 cycle, where stall=0 (bypass).
REQ-026 Four loads fired (MAX_LOADS=4), fifth load candidate -> stall=1, o_outstanding=4; writeback same cycle -> stall=0, count stays 4.
REQ-027 Load x0 fires -> o_pending unchanged, o_outstanding=1; ADD rs1=x0 never stalls.
REQ-028 Two loads in flight, drain asserted -> stall=1, DRAIN until both writebacks, o_drain_done pulses 1 cycle, back to RUN.
REQ-029 Writeback rd=7 with nothing pending -> o_err_spurious=1 sticky, count stays 0; rst_n low clears it.
REQ-030 Load x9 fires with i_flush=1 -> no pending/count change; existing pending x3 survives flush.
